halflife_sequencer: RTL

Command-side controller for the up/down half-life counter. It loads an initial count into the counter, then repeatedly waits a programmable period and issues down strobes until the counter's value has halved. It reads the counter's registered output to close the loop and finishes when the count reaches zero. It sits between the user start/config interface and the counter's `rst`/`load`/`down`/`in` inputs; the counter's `up` input is tied low by the integrator.

---
 rtl/halflife_sequencer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/halflife_sequencer.sv
// halflife_sequencer: loads a down-counter, then repeatedly waits a
// programmable period and strobes it down until its value has halved,
// finishing when the count reaches zero.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; captures init/period and clears epoch
// LOAD   | one-cycle load strobe into the counter
// SETTLE | counter now holds init; zero init finishes at once
// WAIT   | period timer running (frozen while pause is high)
// DEC    | down strobes until cnt <= target, then count one halving
// DONE   | one-cycle completion pulse
module halflife_sequencer #(
  parameter int N = 4,
  parameter int P = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic         pause,
  input  logic [N-1:0] init,
  input  logic [P-1:0] period,
  input  logic [N-1:0] cnt,
  output logic         ctr_load,
  output logic         ctr_down,
  output logic [N-1:0] ctr_val,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] epoch
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_WAIT, S_DEC, S_DONE
  } state_t;

  state_t       state;
  logic [P-1:0] period_q;
  logic [P-1:0] period_eff;
  logic [P-1:0] timer;
  logic [N-1:0] target;
  logic [N-1:0] epoch_q;
  logic [N-1:0] epoch_inc;
  logic         quiet;
  logic         reached;

  // A cycle that is being aborted or reset must not strobe the counter.
  assign quiet      = rst | (abort & (state != S_IDLE));
  assign period_eff = (period_q == '0) ? P'(1) : period_q;
  // A count below target (external disturbance) also counts as reached.
  assign reached    = (state == S_DEC) && (cnt <= target);
  assign epoch_inc  = (epoch_q == '1) ? epoch_q : epoch_q + N'(1);

  // Strobes and status decoded from state; epoch shows the new halving
  // already in the terminating DEC cycle.
  always_comb begin
    ctr_load = (state == S_LOAD) && !quiet;
    ctr_down = (state == S_DEC) && (cnt > target) && !quiet;
    busy     = (state != S_IDLE);
    done     = (state == S_DONE) && !quiet;
    epoch    = (reached && !quiet) ? epoch_inc : epoch_q;
  end

  // Sequencer FSM with capture registers, period timer and epoch count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      period_q <= '0;
      timer    <= '0;
      target   <= '0;
      epoch_q  <= '0;
      ctr_val  <= '0;
    end else if (abort && (state != S_IDLE)) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            ctr_val  <= init;
            period_q <= period;
            epoch_q  <= '0;
            state    <= S_LOAD;
          end
        end
        S_LOAD: state <= S_SETTLE;
        S_SETTLE: begin
          if (cnt == '0) begin
            state <= S_DONE;
          end else begin
            timer <= period_eff;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!pause) begin
            if (timer <= P'(1)) begin
              timer  <= '0;
              target <= cnt >> 1;
              state  <= S_DEC;
            end else begin
              timer <= timer - P'(1);
            end
          end
        end
        S_DEC: begin
          if (cnt <= target) begin
            epoch_q <= epoch_inc;
            if (target == '0) begin
              state <= S_DONE;
            end else begin
              timer <= period_eff;
              state <= S_WAIT;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
